// File: rtl/spart_rx_if.sv
// rtl/spart_rx_if.sv - bus bundle between the baud generator/line side and the spart_rx receiver
//
// Purpose: groups the receiver's tick, line, acknowledge and result signals.
// Signals:
//   rx_en     oversample tick (one-cycle pulse)
//   rxd       asynchronous serial line, idles high
//   rd_ack    one-cycle read strobe from the consumer
//   rx_data   last received byte
//   rda       receive data available
//   frame_err stop bit of the last completed frame was low
//   overrun   a frame completed while rda was still set
//   busy      receiver is inside a frame
// Modports: master drives tick/line/ack and observes results; slave is the receiver.
interface spart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_en;
  logic                 rxd;
  logic                 rd_ack;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rda;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    output rx_en, rxd, rd_ack,
    input  rx_data, rda, frame_err, overrun, busy
  );

  modport slave (
    input  rx_en, rxd, rd_ack,
    output rx_data, rda, frame_err, overrun, busy
  );
endinterface

// File: rtl/spart_rx.sv
// rtl/spart_rx.sv - oversampling 8N1 UART receive stage with data-available/error flags
//
// Purpose: synchronizes rxd, finds the start bit, samples each bit at its centre
// using the OVS-times oversample tick, and presents the byte plus status flags.
// Ports:
//   clk  system clock
//   rst  synchronous active-low reset
//   bus  spart_rx_if slave: rx_en, rxd, rd_ack in; rx_data, rda, frame_err,
//        overrun, busy out
module spart_rx #(
  parameter int OVS       = 16,
  parameter int DATA_BITS = 8
) (
  input  logic   clk,
  input  logic   rst,
  spart_rx_if.slave bus
);

  localparam int CW = $clog2(OVS);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_MID  = CW'(OVS / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 rda_q, rda_d;
  logic                 fe_q, fe_d;
  logic                 ovr_q, ovr_d;
  logic                 wait_hi_q, wait_hi_d;
  logic                 sync1_q, sync1_d;
  logic                 rxd_s_q, rxd_s_d;
  logic                 complete;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      rda_q     <= 1'b0;
      fe_q      <= 1'b0;
      ovr_q     <= 1'b0;
      wait_hi_q <= 1'b0;
      sync1_q   <= 1'b1;
      rxd_s_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      rda_q     <= rda_d;
      fe_q      <= fe_d;
      ovr_q     <= ovr_d;
      wait_hi_q <= wait_hi_d;
      sync1_q   <= sync1_d;
      rxd_s_q   <= rxd_s_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    data_d    = data_q;
    rda_d     = rda_q;
    fe_d      = fe_q;
    ovr_d     = ovr_q;
    wait_hi_d = wait_hi_q;
    sync1_d   = bus.rxd;
    rxd_s_d   = sync1_q;
    complete  = 1'b0;

    if (bus.rx_en) begin
      unique case (state_q)
        IDLE: begin
          // After a frame ended with a low stop bit (e.g. a break), the line
          // must be seen high once before another start bit is accepted.
          if (wait_hi_q) begin
            if (rxd_s_q) wait_hi_d = 1'b0;
          end else if (!rxd_s_q) begin
            state_d = START;
            cnt_d   = '0;
          end
        end
        START: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_MID) begin
            cnt_d = '0;
            bit_d = '0;
            // A start bit that is high again at its centre was only a glitch.
            state_d = rxd_s_q ? IDLE : DATA;
          end
        end
        DATA: begin
          // OVS is a power of two, so the counter wraps naturally.
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            shift_d = {rxd_s_q, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == BIT_LAST) begin
              state_d = STOP;
              cnt_d   = '0;
            end
          end
        end
        STOP: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            complete = 1'b1;
            state_d  = IDLE;
            cnt_d    = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (complete) begin
      // The new byte always overwrites; an ack on this same edge consumes the
      // old byte, so it cannot count as an overrun.
      data_d    = shift_q;
      fe_d      = ~rxd_s_q;
      wait_hi_d = ~rxd_s_q;
      rda_d     = 1'b1;
      if (bus.rd_ack)  ovr_d = 1'b0;
      else if (rda_q)  ovr_d = 1'b1;
    end else if (bus.rd_ack && rda_q) begin
      rda_d = 1'b0;
      ovr_d = 1'b0;
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rda       = rda_q;
  assign bus.frame_err = fe_q;
  assign bus.overrun   = ovr_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spart_rx.sv
// tb/tb_spart_rx.sv - self-checking bench for spart_rx
module tb_spart_rx;

  localparam int BIT_CLKS = 64;  // rx_en every 4 clk, 16 ticks per bit
  localparam int FRAME_TICKS = 152; // ticks from start detection to mid-stop

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Reference model of the bus-visible state
  logic [7:0] m_data;
  logic       m_rda;
  logic       m_fe;
  logic       m_ovr;

  spart_rx_if #(.DATA_BITS(8)) bus ();

  spart_rx #(.OVS(16), .DATA_BITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oversample tick generator: one-cycle pulse every 4 clocks
  initial begin
    bus.rx_en = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 bus.rx_en = 1'b1;
      @(posedge clk);
      #1 bus.rx_en = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic void m_reset();
    m_data = 8'h00; m_rda = 1'b0; m_fe = 1'b0; m_ovr = 1'b0;
  endfunction

  function automatic void m_complete(input logic [7:0] b, input logic stop, input logic ack);
    if (ack) m_ovr = 1'b0;
    else if (m_rda) m_ovr = 1'b1;
    m_data = b;
    m_fe   = ~stop;
    m_rda  = 1'b1;
  endfunction

  function automatic void m_ack();
    if (m_rda) begin
      m_rda = 1'b0;
      m_ovr = 1'b0;
    end
  endfunction

  task automatic line(input logic v, input int clks);
    bus.rxd = v;
    repeat (clks) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    line(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) line(b[i], BIT_CLKS);
    line(stop, BIT_CLKS);
  endtask

  task automatic pulse_ack();
    bus.rd_ack = 1'b1;
    @(posedge clk);
    #1 bus.rd_ack = 1'b0;
    m_ack();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    line(1'b0, 3);
    m_reset();
    checks++;
    if ({bus.rx_data, bus.rda, bus.frame_err, bus.overrun, bus.busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h rda=%b fe=%b ovr=%b busy=%b, required all 0",
               bus.rx_data, bus.rda, bus.frame_err, bus.overrun, bus.busy);
    end
    rst = 1'b1;
    line(1'b1, 200);
    checks++;
    if (bus.rda !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got rda=%b busy=%b, required 0 0", bus.rda, bus.busy);
    end
  endtask

  task automatic test_single();
    fork
      send_frame(8'hA5, 1'b1);
      begin
        repeat (300) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b1) begin
          errors++;
          $display("FAIL busy_mid_frame: got %b, required 1", bus.busy);
        end
      end
    join
    m_complete(8'hA5, 1'b1, 1'b0);
    checks++;
    if (bus.rx_data !== m_data || bus.rda !== m_rda || bus.frame_err !== m_fe || bus.overrun !== m_ovr) begin
      errors++;
      $display("FAIL single_byte: got data=%h rda=%b fe=%b ovr=%b, required data=%h rda=%b fe=%b ovr=%b",
               bus.rx_data, bus.rda, bus.frame_err, bus.overrun, m_data, m_rda, m_fe, m_ovr);
    end
    pulse_ack();
    checks++;
    if (bus.rda !== 1'b0 || bus.rx_data !== 8'hA5) begin
      errors++;
      $display("FAIL single_ack: got rda=%b data=%h, required rda=0 data=a5", bus.rda, bus.rx_data);
    end
  endtask

  task automatic test_glitch();
    line(1'b0, 20);
    line(1'b1, 200);
    checks++;
    if (bus.busy !== 1'b0 || bus.rda !== m_rda) begin
      errors++;
      $display("FAIL glitch_reject: got busy=%b rda=%b, required busy=0 rda=%b", bus.busy, bus.rda, m_rda);
    end
    send_frame(8'h3C, 1'b1);
    m_complete(8'h3C, 1'b1, 1'b0);
    checks++;
    if (bus.rx_data !== m_data || bus.rda !== m_rda || bus.frame_err !== m_fe) begin
      errors++;
      $display("FAIL glitch_then_byte: got data=%h rda=%b fe=%b, required data=%h rda=%b fe=%b",
               bus.rx_data, bus.rda, bus.frame_err, m_data, m_rda, m_fe);
    end
    pulse_ack();
  endtask

  task automatic test_frame_err();
    send_frame(8'h55, 1'b0);
    m_complete(8'h55, 1'b0, 1'b0);
    checks++;
    if (bus.rx_data !== m_data || bus.rda !== m_rda || bus.frame_err !== m_fe) begin
      errors++;
      $display("FAIL frame_err_set: got data=%h rda=%b fe=%b, required data=%h rda=%b fe=%b",
               bus.rx_data, bus.rda, bus.frame_err, m_data, m_rda, m_fe);
    end
    pulse_ack();
    checks++;
    if (bus.frame_err !== 1'b1 || bus.rda !== 1'b0) begin
      errors++;
      $display("FAIL frame_err_after_ack: got fe=%b rda=%b, required fe=1 rda=0", bus.frame_err, bus.rda);
    end
    line(1'b1, BIT_CLKS);
    send_frame(8'h0F, 1'b1);
    m_complete(8'h0F, 1'b1, 1'b0);
    checks++;
    if (bus.rx_data !== m_data || bus.frame_err !== m_fe || bus.rda !== m_rda) begin
      errors++;
      $display("FAIL frame_err_clear: got data=%h fe=%b rda=%b, required data=%h fe=%b rda=%b",
               bus.rx_data, bus.frame_err, bus.rda, m_data, m_fe, m_rda);
    end
    pulse_ack();
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1);
    m_complete(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1);
    m_complete(8'h22, 1'b1, 1'b0);
    checks++;
    if (bus.rx_data !== m_data || bus.rda !== m_rda || bus.overrun !== m_ovr) begin
      errors++;
      $display("FAIL overrun_set: got data=%h rda=%b ovr=%b, required data=%h rda=%b ovr=%b",
               bus.rx_data, bus.rda, bus.overrun, m_data, m_rda, m_ovr);
    end
    pulse_ack();
    checks++;
    if (bus.rda !== m_rda || bus.overrun !== m_ovr) begin
      errors++;
      $display("FAIL overrun_ack: got rda=%b ovr=%b, required rda=%b ovr=%b",
               bus.rda, bus.overrun, m_rda, m_ovr);
    end
  endtask

  task automatic test_simul_ack();
    send_frame(8'h11, 1'b1);
    m_complete(8'h11, 1'b1, 1'b0);
    fork
      send_frame(8'h77, 1'b1);
      begin
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        wait (bus.rxd === 1'b0);
        @(posedge clk);
        @(posedge clk);
        // At edge+2 rx_en shows what the next edge samples; the receiver sees
        // the start bit from the third edge after the line falls.
        for (int k = 0; k < 4000 && !done; k++) begin
          #2;
          if (bus.rx_en) begin
            if (n == FRAME_TICKS) begin
              bus.rd_ack = 1'b1;
              @(posedge clk);
              #1 bus.rd_ack = 1'b0;
              done = 1'b1;
            end else begin
              n++;
            end
          end
          if (!done) @(posedge clk);
        end
        checks++;
        if (!done) begin
          errors++;
          $display("FAIL simul_ack_timing: completion tick not reached, got n=%0d required %0d", n, FRAME_TICKS);
        end
      end
    join
    m_complete(8'h77, 1'b1, 1'b1);
    checks++;
    if (bus.rx_data !== m_data || bus.rda !== m_rda || bus.overrun !== m_ovr) begin
      errors++;
      $display("FAIL simul_ack: got data=%h rda=%b ovr=%b, required data=%h rda=%b ovr=%b",
               bus.rx_data, bus.rda, bus.overrun, m_data, m_rda, m_ovr);
    end
    pulse_ack();
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'hC3;
    line(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) line(b[i], BIT_CLKS);
    line(b[4], BIT_CLKS / 2);
    rst = 1'b0;
    line(b[4], 3);
    rst = 1'b1;
    m_reset();
    line(1'b1, 2 * BIT_CLKS);
    checks++;
    if ({bus.rx_data, bus.rda, bus.frame_err, bus.overrun, bus.busy} !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_frame: got data=%h rda=%b fe=%b ovr=%b busy=%b, required all 0",
               bus.rx_data, bus.rda, bus.frame_err, bus.overrun, bus.busy);
    end
    send_frame(8'hC3, 1'b1);
    m_complete(8'hC3, 1'b1, 1'b0);
    checks++;
    if (bus.rx_data !== m_data || bus.rda !== m_rda || bus.frame_err !== m_fe || bus.overrun !== m_ovr) begin
      errors++;
      $display("FAIL after_reset_byte: got data=%h rda=%b fe=%b ovr=%b, required data=%h rda=%b fe=%b ovr=%b",
               bus.rx_data, bus.rda, bus.frame_err, bus.overrun, m_data, m_rda, m_fe, m_ovr);
    end
    pulse_ack();
  endtask

  task automatic test_break();
    line(1'b0, 10 * BIT_CLKS + 240);
    m_complete(8'h00, 1'b0, 1'b0);
    checks++;
    if (bus.rx_data !== m_data || bus.rda !== m_rda || bus.frame_err !== m_fe || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL break: got data=%h rda=%b fe=%b busy=%b, required data=%h rda=%b fe=%b busy=0",
               bus.rx_data, bus.rda, bus.frame_err, bus.busy, m_data, m_rda, m_fe);
    end
    line(1'b1, BIT_CLKS);
    pulse_ack();
    send_frame(8'h5A, 1'b1);
    m_complete(8'h5A, 1'b1, 1'b0);
    checks++;
    if (bus.rx_data !== m_data || bus.frame_err !== m_fe || bus.overrun !== m_ovr) begin
      errors++;
      $display("FAIL after_break: got data=%h fe=%b ovr=%b, required data=%h fe=%b ovr=%b",
               bus.rx_data, bus.frame_err, bus.overrun, m_data, m_fe, m_ovr);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic       stop;
    for (int it = 0; it < 12; it++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop);
      m_complete(b, stop, 1'b0);
      checks++;
      if (bus.rx_data !== m_data || bus.rda !== m_rda || bus.frame_err !== m_fe ||
          bus.overrun !== m_ovr || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL random[%0d]: got data=%h rda=%b fe=%b ovr=%b busy=%b, required data=%h rda=%b fe=%b ovr=%b busy=0",
                 it, bus.rx_data, bus.rda, bus.frame_err, bus.overrun, bus.busy, m_data, m_rda, m_fe, m_ovr);
      end
      if ($urandom_range(0, 1) == 1) pulse_ack();
      if (!stop || $urandom_range(0, 1) == 1) line(1'b1, BIT_CLKS);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b0;
    bus.rxd    = 1'b1;
    bus.rd_ack = 1'b0;
    m_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_simul_ack();
    test_reset_mid();
    test_break();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
